// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver: sync, 3-sample vote, parity/frame/overrun, valid/ready
// Define UART_RX_BREAK_EN to add break_det and a BREAK wait state.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_BREAK_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam int RAW_DIV  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_DIV = (RAW_DIV < 1) ? 1 : RAW_DIV;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW       = $clog2(DATA_BITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [PW-1:0]        presc_q, presc_d;
  logic [3:0]           tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 s7_q, s7_d, s8_q, s8_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 deliver_q, deliver_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_BREAK_EN
  logic                 ones_q, ones_d;
  logic                 brk_q, brk_d;
`endif

  logic tick, rx_s, maj, par_calc, accept;

  assign tick     = (presc_q == PRESC_MAX);
  assign rx_s     = sync2_q;
  assign maj      = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  assign par_calc = (^shreg_q) ^ ODD_PAR;
  assign accept   = valid_q & data_ready;

  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + PW'(1);
    tick_d     = tick_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    deliver_d  = 1'b0;
    dout_d     = dout_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
`ifdef UART_RX_BREAK_EN
    ones_d     = ones_q;
    brk_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          presc_d = '0;
          tick_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_EN
          ones_d  = 1'b0;
`endif
        end
      end
`ifdef UART_RX_BREAK_EN
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
`endif
      default: begin
        if (tick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd7) s7_d = rx_s;
          if (tick_q == 4'd8) s8_d = rx_s;
`ifdef UART_RX_BREAK_EN
          if (tick_q == 4'd9 && state_q != S_START) ones_d = ones_q | maj;
`endif
          case (state_q)
            S_START: begin
              if (tick_q == 4'd9 && maj) state_d = S_IDLE;
              else if (tick_q == 4'd15)  state_d = S_DATA;
            end
            S_DATA: begin
              if (tick_q == 4'd9) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
              if (tick_q == 4'd15) begin
                if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                else                   bit_d   = bit_q + BW'(1);
              end
            end
            S_PARITY: begin
              if (tick_q == 4'd9)  perr_d  = maj ^ par_calc;
              if (tick_q == 4'd15) state_d = S_STOP;
            end
            S_STOP: begin
              if (tick_q == 4'd9) begin
                if (!maj) ferr_d = 1'b1;
                // The last stop bit ends at its centre so the next start edge is never missed
                if (stop_q == STOP_LAST) begin
                  state_d   = S_IDLE;
                  deliver_d = 1'b1;
`ifdef UART_RX_BREAK_EN
                  if (!(ones_q | maj)) begin
                    state_d   = S_BREAK;
                    deliver_d = 1'b0;
                    brk_d     = 1'b1;
                  end
`endif
                end
              end
              if (tick_q == 4'd15) stop_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase

    if (deliver_q) begin
      if (!valid_q || accept) begin
        dout_d     = shreg_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      presc_q    <= '0;
      tick_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      s7_q       <= 1'b0;
      s8_q       <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      deliver_q  <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_EN
      ones_q     <= 1'b0;
      brk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      deliver_q  <= deliver_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_EN
      ones_q     <= ones_d;
      brk_q      <= brk_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_EN
  assign break_det  = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - bench for uart_rx_param: 8N1, 7E1 and 8O2 receivers against a frame-level model
// Define UART_RX_BREAK_EN to also exercise break detection.
module tb_uart_rx_param;

  logic clk, rst_n;
  logic rx_a, rdy_a, val_a, pe_a, fe_a, ov_a, busy_a;
  logic rx_b, rdy_b, val_b, pe_b, fe_b, ov_b, busy_b;
  logic rx_c, rdy_c, val_c, pe_c, fe_c, ov_c, busy_c;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic [7:0] dout_c;
`ifdef UART_RX_BREAK_EN
  logic brk_a, brk_b, brk_c;
  int   brka;
`endif

  int checks, errors, ova;
  logic [10:0] qa[$], qb[$], qc[$];
  int NB[3] = '{8, 7, 8};
  int PM[3] = '{0, 1, 2};
  int NS[3] = '{1, 1, 2};

  uart_rx_param #(.CLK_FREQ(1600000), .BAUD_RATE(100000)) u_a (
    .clk(clk), .reset(rst_n), .rx(rx_a), .data_out(dout_a), .data_valid(val_a),
    .data_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a),
`ifdef UART_RX_BREAK_EN
    .break_det(brk_a),
`endif
    .busy(busy_a));

  uart_rx_param #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1)) u_b (
    .clk(clk), .reset(rst_n), .rx(rx_b), .data_out(dout_b), .data_valid(val_b),
    .data_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b),
`ifdef UART_RX_BREAK_EN
    .break_det(brk_b),
`endif
    .busy(busy_b));

  uart_rx_param #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY(2), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(rst_n), .rx(rx_c), .data_out(dout_c), .data_valid(val_c),
    .data_ready(rdy_c), .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c),
`ifdef UART_RX_BREAK_EN
    .break_det(brk_c),
`endif
    .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (val_a && rdy_a) qa.push_back({fe_a, pe_a, 1'b0, dout_a});
    if (val_b && rdy_b) qb.push_back({fe_b, pe_b, 2'b00, dout_b});
    if (val_c && rdy_c) qc.push_back({fe_c, pe_c, 1'b0, dout_c});
    if (ov_a) ova++;
`ifdef UART_RX_BREAK_EN
    if (brk_a) brka++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  function automatic int qsz(input int sel);
    case (sel)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic drive(input int sel, input logic [15:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, fr[i]);
      repeat (16) @(negedge clk);
    end
    set_rx(sel, 1'b1);
    repeat (16) @(negedge clk);
  endtask

  // Builds the line waveform from the word and derives what the receiver must report.
  task automatic send(input int sel, input logic [8:0] w, input bit flip, input bit [1:0] sz,
                      output logic [10:0] exp);
    logic [15:0] fr;
    logic [8:0]  d;
    int n, ones;
    bit pb, perr, fe;
    fr = '1;
    d = '0;
    ones = 0;
    fr[0] = 1'b0;
    for (int i = 0; i < NB[sel]; i++) begin
      d[i] = w[i];
      fr[1 + i] = w[i];
      ones += int'(w[i]);
    end
    n = 1 + NB[sel];
    perr = 1'b0;
    if (PM[sel] != 0) begin
      pb = ((ones % 2) == 1) ^ (PM[sel] == 2) ^ flip;
      fr[n] = pb;
      n++;
      ones += int'(pb);
      perr = (PM[sel] == 1) ? ((ones % 2) != 0) : ((ones % 2) != 1);
    end
    fe = 1'b0;
    for (int s = 0; s < NS[sel]; s++) begin
      fr[n] = ~sz[s];
      if (sz[s]) fe = 1'b1;
      n++;
    end
    exp = {fe, perr, d};
    drive(sel, fr, n);
  endtask

  task automatic check_rx(input int sel, input logic [10:0] exp, input string tag);
    logic [10:0] got;
    int i;
    i = 0;
    while (qsz(sel) == 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_avail"}, 32'(qsz(sel) != 0), 32'd1);
    if (qsz(sel) != 0) begin
      case (sel)
        0: got = qa.pop_front();
        1: got = qb.pop_front();
        default: got = qc.pop_front();
      endcase
      chk({tag, "_data"}, 32'(got[8:0]), 32'(exp[8:0]));
      chk({tag, "_perr"}, 32'(got[9]), 32'(exp[9]));
      chk({tag, "_ferr"}, 32'(got[10]), 32'(exp[10]));
    end
  endtask

  initial begin
    logic [10:0] e, e1;
    logic [8:0] w;
    checks = 0; errors = 0; ova = 0;
`ifdef UART_RX_BREAK_EN
    brka = 0;
`endif
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout_a), 32'd0);
    chk("rst_valid", 32'(val_a), 32'd0);
    chk("rst_perr", 32'(pe_a), 32'd0);
    chk("rst_ferr", 32'(fe_a), 32'd0);
    chk("rst_ovr", 32'(ov_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_valid_c", 32'(val_c), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send(0, 9'h0A5, 1'b0, 2'b00, e);
    check_rx(0, e, "a5");
    chk("a5_once", 32'(qsz(0)), 32'd0);

    send(1, 9'h055, 1'b0, 2'b00, e);
    check_rx(1, e, "p55_ok");
    send(1, 9'h055, 1'b1, 2'b00, e);
    check_rx(1, e, "p55_bad");

    set_rx(0, 1'b0);
    repeat (4) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2) @(negedge clk);
    chk("glitch_busy", 32'(busy_a), 32'd1);
    repeat (20) @(negedge clk);
    chk("glitch_idle", 32'(busy_a), 32'd0);
    chk("glitch_noword", 32'(qsz(0)), 32'd0);
    send(0, 9'h03C, 1'b0, 2'b00, e);
    check_rx(0, e, "3c");

    send(0, 9'h081, 1'b0, 2'b01, e);
    check_rx(0, e, "81_stop0");
    send(2, 9'h05A, 1'b0, 2'b10, e);
    check_rx(2, e, "stop2_0");
    send(2, 9'h05A, 1'b0, 2'b00, e);
    check_rx(2, e, "8o2_ok");

    rdy_a = 1'b0;
    send(0, 9'h011, 1'b0, 2'b00, e1);
    send(0, 9'h022, 1'b0, 2'b00, e);
    chk("ovr_valid", 32'(val_a), 32'd1);
    chk("ovr_hold", 32'(dout_a), 32'h11);
    chk("ovr_count", 32'(ova), 32'd1);
    @(posedge clk);
    #1 rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_drop", 32'(val_a), 32'd0);
    check_rx(0, e1, "ovr_first");
    repeat (40) @(negedge clk);
    chk("ovr_no22", 32'(qsz(0)), 32'd0);

    set_rx(0, 1'b0);
    repeat (16) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_dout", 32'(dout_a), 32'd0);
    rst_n = 1'b1;
    repeat (32) @(negedge clk);
    chk("midrst_noword", 32'(qsz(0)), 32'd0);
    send(0, 9'h00F, 1'b0, 2'b00, e);
    check_rx(0, e, "0f");
    chk("0f_only", 32'(qsz(0)), 32'd0);

    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 3; s++) begin
        w = 9'($urandom) | 9'h001;
        send(s, w, 1'($urandom), 2'($urandom), e);
        check_rx(s, e, $sformatf("rnd%0d_%0d", s, k));
      end
    end

`ifdef UART_RX_BREAK_EN
    set_rx(0, 1'b0);
    repeat (12 * 16) @(negedge clk);
    chk("brk_busy", 32'(busy_a), 32'd1);
    chk("brk_pulse", 32'(brka), 32'd1);
    set_rx(0, 1'b1);
    repeat (24) @(negedge clk);
    chk("brk_idle", 32'(busy_a), 32'd0);
    chk("brk_noword", 32'(qsz(0)), 32'd0);
`else
    send(0, 9'h000, 1'b0, 2'b01, e);
    check_rx(0, e, "brk_word");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver and the next generation of the team's Bluetooth-module receive path.
- Adds the following over a fixed 8N1 receiver:
  - configurable data width, parity and stop bits
  - 2-flop input synchroniser and 3-sample majority voting at bit centre
  - false-start rejection
  - parity, framing and overrun detection
  - valid/ready output handshake
- Sits between the BT module RX pin and the command decoder.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD_RATE, 9600, line rate in baud.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, other values unsupported.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- rx  in  1  asynchronous serial input; idle high.
- data_out  out  DATA_BITS  received word, LSB received first.
- data_valid  out  1  data_out, parity_err and frame_err are valid.
- data_ready  in  1  consumer accepts the word when data_valid & data_ready.
- parity_err  out  1  parity mismatch for the held word.
- frame_err  out  1  a stop bit was sampled 0 for the held word.
- overrun  out  1  one-cycle pulse: a frame completed while data_valid was high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset).
- Reset values:
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops = 1; FSM = IDLE; all counters = 0.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD_RATE*16), integer truncation; minimum 1.
  - Produces a one-cycle tick every TICK_DIV clocks.
  - Prescaler is cleared on start detection, so ticks are phase-aligned to the falling edge.
- Sampling: ticks within a bit are numbered 0..15. Samples are taken at ticks 7, 8 and 9; the bit value is the majority of the 3, decided at tick 9.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: synchronised rx==0 -> START, tick count 0.
  - START: at tick 9, majority=1 -> IDLE (false start, no outputs change). Otherwise at tick 15 -> DATA.
  - DATA: shift in LSB first. After bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
  - PARITY: compare the majority sample against the computed parity (even: XOR of data; odd: inverted XOR); latch the mismatch. After tick 15 -> STOP.
  - STOP:
    - Each stop bit sampled at tick 9; any 0 sets frame_err.
    - With STOP_BITS=2, the first stop bit runs to tick 15.
    - The last stop bit ends at its tick 9: deliver, then IDLE. This allows resync at mid-stop.
- Delivery (cycle after the last stop-bit decision):
  - If data_valid=0: load data_out, parity_err and frame_err; data_valid=1.
  - If data_valid=1 and not being accepted in that same cycle: drop the new frame, keep the old word, pulse overrun for 1 cycle.
  - Same-cycle accept and deliver: the new word loads and data_valid stays 1; no overrun.
- Handshake:
  - data_valid&data_ready -> data_valid=0 the next cycle.
  - data_out and flags stay stable while data_valid=1.
- Frames with errors are still delivered, with their flags set.
- Reset asserted mid-frame: immediate return to reset values and any partial frame is discarded.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- Defined:
  - Adds output break_det (1 bit, reset 0).
  - If all data, parity and stop samples are 0, no word is delivered and break_det pulses 1 cycle.
  - FSM then waits in a BREAK state until synchronised rx==1, then returns to IDLE; busy=1 throughout.
- Undefined:
  - A break is delivered as data_out=0 with frame_err=1.
  - Receiver returns to IDLE and may immediately restart on the still-low line.

Test Plan:
- Bench setup for all scenarios:
  - Parameters CLK_FREQ=1600000, BAUD_RATE=100000 (TICK_DIV=1, 16 clk/bit).
  - data_ready tied 1 unless noted.
- 8N1, send 0xA5 -> data_valid pulses once, data_out=0xA5, parity_err=0, frame_err=0.
- PARITY=1, DATA_BITS=7:
  - Send 0x55 with parity bit 0 -> data_out=0x55, parity_err=0.
  - Repeat with parity bit 1 -> parity_err=1.
- rx low for 4 clocks then high (glitch) -> FSM returns to IDLE after the tick-9 decision; no data_valid. Then send 0x3C -> received correctly.
- Stop bit driven 0 on 0x81 -> data_out=0x81, frame_err=1. STOP_BITS=2 with second stop bit 0 -> frame_err=1.
- data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once. Then assert data_ready -> data_valid drops, no 0x22 appears.
- Pull reset low mid-data of 0xFF, release, send 0x0F -> only 0x0F delivered. With UART_RX_BREAK_EN, hold rx low for 12 bits -> break_det pulse, no data_valid.
